parallel_to_serial_stream: RTL and testbench
============================================

// Module: parallel_to_serial_stream
// PURPOSE
//   Takes one INPUT_SIZE-bit parallel word over a ready-valid stream and emits it as
//   INPUT_SIZE/OUTPUT_SIZE consecutive OUTPUT_SIZE-bit elements on a ready-valid stream.
//   It is the transmit-side counterpart of the serial-to-parallel stream deserialiser.
//   Its default order (MSB_FIRST=1) matches a deserialiser that shifts in at the LSB.
//   It sits between word producers (e.g. FIFOs, result registers) and narrow serial links.
// PARAMETERS
//   INPUT_SIZE   8   parallel word width; must be divisible by OUTPUT_SIZE (else $error at elaboration)
//   OUTPUT_SIZE  1   serial element width
//   MSB_FIRST    1   1: most-significant element sent first; 0: least-significant first
// PORTS
//   clk                 in   1            single clock; all state on posedge
//   rst                 in   1            synchronous, active-high reset
//   parallel_in_ready   out  1            block can accept a word this cycle
//   parallel_in_valid   in   1            producer presents parallel_in_data
//   parallel_in_data    in   INPUT_SIZE   word to serialise
//   serial_out_ready    in   1            consumer accepts current element
//   serial_out_valid    out  1            serial_out_data holds a valid element
//   serial_out_data     out  OUTPUT_SIZE  current element
//   serial_out_last     out  1            current element is the final element of its word
// BEHAVIOUR
//   - ELEMENT_COUNT = INPUT_SIZE/OUTPUT_SIZE. State: buffer[INPUT_SIZE], remaining count 0..ELEMENT_COUNT.
//   - Reset (rst high at posedge): buffer<=0, remaining<=0. While rst is high, parallel_in_ready=0,
//     serial_out_valid=0, serial_out_last=0, serial_out_data=0. First cycle after release: parallel_in_ready=1.
//   - Reset mid-word discards the unsent elements; no partial word is emitted afterwards.
//   - serial_out_valid = (remaining != 0); serial_out_last = (remaining == 1).
//   - serial_out_data = buffer[INPUT_SIZE-1 -: OUTPUT_SIZE] if MSB_FIRST, else buffer[OUTPUT_SIZE-1:0].
//   - Output transfer (serial_out_valid && serial_out_ready): buffer shifts by OUTPUT_SIZE toward the
//     read end, vacated bits are filled with 0, and remaining decrements.
//   - parallel_in_ready = !rst && (remaining==0 || (remaining==1 && serial_out_ready)). It is combinational
//     on serial_out_ready; there is no combinational path from parallel_in_valid to any output.
//   - Input transfer (parallel_in_valid && parallel_in_ready): buffer<=parallel_in_data,
//     remaining<=ELEMENT_COUNT. This takes priority over the shift when both fire in the same cycle
//     (last element out, next word in). The result is zero-bubble back-to-back throughput.
//   - Latency: a word accepted at edge N presents its first element with valid=1 in the cycle after N.
//     No combinational input->output data path.
//   - Backpressure: while serial_out_valid && !serial_out_ready, serial_out_data, serial_out_last and
//     remaining stay stable, and parallel_in_ready stays 0.
//   - ELEMENT_COUNT==1: behaves as a one-deep register slice with serial_out_last=1 whenever valid.
//   - Idle (remaining==0): serial_out_data is don't-care (buffer contents); the bench must not check it.
// TESTING (defaults unless stated)
//   1. Reset, then 0xA5 with serial_out_ready=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles,
//      last=1 only on the 8th, valid=0 afterwards.
//   2. 0xA5 then 0x3C offered back-to-back, ready=1 -> 16 consecutive valid bits with no bubble;
//      parallel_in_ready=1 in the cycle of 0xA5's 8th bit.
//   3. 0xA5, serial_out_ready=0 for 3 cycles while the 3rd bit is shown -> data=1 held for 3 cycles,
//      parallel_in_ready=0 throughout; the stream then resumes correctly.
//   4. INPUT_SIZE=16, OUTPUT_SIZE=4, MSB_FIRST=0, word 0x1234 -> elements 4,3,2,1; last with element 1.
//   5. rst pulsed for 1 cycle after 3 bits of 0xA5 -> valid=0 during reset; then 0xFF -> exactly 8 ones,
//      with no leftover 0xA5 bits.
//   6. Random valid/ready throttling on both sides, 1000 words, compared against a scoreboard
//      -> no lost, duplicated or reordered elements.

Source files
------------

// File: rtl/parallel_to_serial_stream_if.sv
// parallel_to_serial_stream_if: word-in and element-out ready/valid handshakes
interface parallel_to_serial_stream_if #(
  parameter int INPUT_SIZE  = 8,
  parameter int OUTPUT_SIZE = 1
);
  logic                   parallel_in_ready;
  logic                   parallel_in_valid;
  logic [INPUT_SIZE-1:0]  parallel_in_data;
  logic                   serial_out_ready;
  logic                   serial_out_valid;
  logic [OUTPUT_SIZE-1:0] serial_out_data;
  logic                   serial_out_last;
  modport master (
    input  parallel_in_ready,
    output parallel_in_valid, parallel_in_data,
    output serial_out_ready,
    input  serial_out_valid, serial_out_data, serial_out_last
  );
  modport slave (
    output parallel_in_ready,
    input  parallel_in_valid, parallel_in_data,
    input  serial_out_ready,
    output serial_out_valid, serial_out_data, serial_out_last
  );
endinterface

// File: rtl/parallel_to_serial_stream.sv
// parallel_to_serial_stream: splits one parallel word into OUTPUT_SIZE-bit stream elements
module parallel_to_serial_stream #(
  parameter int INPUT_SIZE  = 8,
  parameter int OUTPUT_SIZE = 1,
  parameter bit MSB_FIRST   = 1
) (
  input logic clk,
  input logic rst,
  parallel_to_serial_stream_if.slave bus
);
  localparam int ELEMENT_COUNT = INPUT_SIZE / OUTPUT_SIZE;
  localparam int CW = $clog2(ELEMENT_COUNT + 1);
  localparam logic [CW-1:0] FULL = CW'(ELEMENT_COUNT);
  if (INPUT_SIZE % OUTPUT_SIZE != 0) begin : g_size_check
    $error("INPUT_SIZE must be divisible by OUTPUT_SIZE");
  end
  logic [INPUT_SIZE-1:0] buffer;
  logic [CW-1:0]         remaining;
  logic                  in_fire;
  logic                  out_fire;
  // handshakes and the read end of the buffer; everything forced quiet while in reset
  always_comb begin
    bus.parallel_in_ready = !rst && (remaining == '0 || (remaining == CW'(1) && bus.serial_out_ready));
    bus.serial_out_valid  = !rst && remaining != '0;
    bus.serial_out_last   = !rst && remaining == CW'(1);
    bus.serial_out_data   = rst ? '0 : MSB_FIRST ? buffer[INPUT_SIZE-1 -: OUTPUT_SIZE] : buffer[OUTPUT_SIZE-1:0];
    in_fire               = bus.parallel_in_valid && bus.parallel_in_ready;
    out_fire              = bus.serial_out_valid && bus.serial_out_ready;
  end
  // a new word overrides the shift so the last element and the next word overlap with no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer    <= '0;
      remaining <= '0;
    end else if (in_fire) begin
      buffer    <= bus.parallel_in_data;
      remaining <= FULL;
    end else if (out_fire) begin
      buffer    <= MSB_FIRST ? buffer << OUTPUT_SIZE : buffer >> OUTPUT_SIZE;
      remaining <= remaining - CW'(1);
    end
  end
endmodule

// File: tb/tb_parallel_to_serial_stream.sv
// tb_parallel_to_serial_stream: directed and randomized checks against a queue scoreboard
module tb_parallel_to_serial_stream;
  logic clk = 0;
  logic rst = 1;
  int compared = 0;
  int mismatched = 0;
  logic [32:0] sb [2][$];
  logic [15:0] pair = 16'hA53C;
  logic [31:0] wexp;
  int sent8, sent16, cyc8, cyc16;
  bit acc8, acc16;

  parallel_to_serial_stream_if #(.INPUT_SIZE(8), .OUTPUT_SIZE(1)) b8 ();
  parallel_to_serial_stream_if #(.INPUT_SIZE(16), .OUTPUT_SIZE(4)) b16 ();

  parallel_to_serial_stream #(.INPUT_SIZE(8), .OUTPUT_SIZE(1), .MSB_FIRST(1)) dut8 (
    .clk(clk), .rst(rst), .bus(b8.slave));
  parallel_to_serial_stream #(.INPUT_SIZE(16), .OUTPUT_SIZE(4), .MSB_FIRST(0)) dut16 (
    .clk(clk), .rst(rst), .bus(b16.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reference: each accepted word becomes a queue of {last, element} computed by plain arithmetic
  task automatic mon(input int id, input int w, input int o, input bit msb,
                     input logic piv, input logic pir, input logic [31:0] pid,
                     input logic sor, input logic sov, input logic [31:0] sod, input logic sol);
    int n;
    logic [32:0] f;
    n = sb[id].size();
    if (rst) begin
      check($sformatf("rst_ready%0d", id), 32'(pir), 32'd0);
      check($sformatf("rst_valid%0d", id), 32'(sov), 32'd0);
      check($sformatf("rst_last%0d", id), 32'(sol), 32'd0);
      check($sformatf("rst_data%0d", id), sod, 32'd0);
      sb[id].delete();
    end else begin
      check($sformatf("ready%0d", id), 32'(pir), 32'(n == 0 || (n == 1 && sor)));
      check($sformatf("valid%0d", id), 32'(sov), 32'(n != 0));
      if (n != 0) begin
        f = sb[id][0];
        check($sformatf("data%0d", id), sod, f[31:0]);
        check($sformatf("last%0d", id), 32'(sol), 32'(f[32]));
        if (sov && sor) void'(sb[id].pop_front());
      end else begin
        check($sformatf("idle_last%0d", id), 32'(sol), 32'd0);
      end
      if (piv && pir)
        for (int i = 0; i < w / o; i++)
          sb[id].push_back({i == w / o - 1, (pid >> (msb ? w - (i + 1) * o : i * o)) & ((32'd1 << o) - 32'd1)});
    end
  endtask

  always @(negedge clk) begin
    mon(0, 8, 1, 1'b1, b8.parallel_in_valid, b8.parallel_in_ready, 32'(b8.parallel_in_data),
        b8.serial_out_ready, b8.serial_out_valid, 32'(b8.serial_out_data), b8.serial_out_last);
    mon(1, 16, 4, 1'b0, b16.parallel_in_valid, b16.parallel_in_ready, 32'(b16.parallel_in_data),
        b16.serial_out_ready, b16.serial_out_valid, 32'(b16.serial_out_data), b16.serial_out_last);
  end

  initial begin
    b8.parallel_in_valid = 0;
    b8.parallel_in_data = '0;
    b8.serial_out_ready = 1;
    b16.parallel_in_valid = 0;
    b16.parallel_in_data = '0;
    b16.serial_out_ready = 1;
    tick;
    tick;
    rst = 0;
    // single word, MSB first
    b8.parallel_in_valid = 1;
    b8.parallel_in_data = 8'hA5;
    @(negedge clk);
    check("t1_ready_after_reset", 32'(b8.parallel_in_ready), 32'd1);
    tick;
    b8.parallel_in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wexp = (32'hA5 >> (7 - i)) & 32'd1;
      check("t1_bit", 32'(b8.serial_out_data), wexp);
      check("t1_last", 32'(b8.serial_out_last), 32'(i == 7));
      tick;
    end
    @(negedge clk);
    check("t1_valid_after", 32'(b8.serial_out_valid), 32'd0);
    // back-to-back words with no bubble
    b8.parallel_in_valid = 1;
    b8.parallel_in_data = 8'hA5;
    tick;
    b8.parallel_in_data = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t2_valid", 32'(b8.serial_out_valid), 32'd1);
      check("t2_bit", 32'(b8.serial_out_data), 32'(pair[15-i]));
      if (i == 7) check("t2_ready_on_last", 32'(b8.parallel_in_ready), 32'd1);
      tick;
      if (i == 7) b8.parallel_in_valid = 0;
    end
    @(negedge clk);
    check("t2_valid_after", 32'(b8.serial_out_valid), 32'd0);
    // backpressure on the third element
    b8.parallel_in_valid = 1;
    b8.parallel_in_data = 8'hA5;
    tick;
    b8.parallel_in_valid = 0;
    tick;
    tick;
    b8.serial_out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_data", 32'(b8.serial_out_data), 32'd1);
      check("t3_hold_valid", 32'(b8.serial_out_valid), 32'd1);
      check("t3_hold_ready", 32'(b8.parallel_in_ready), 32'd0);
      tick;
    end
    b8.serial_out_ready = 1;
    repeat (8) tick;
    @(negedge clk);
    check("t3_valid_after", 32'(b8.serial_out_valid), 32'd0);
    // wide elements, LSB first
    b16.parallel_in_valid = 1;
    b16.parallel_in_data = 16'h1234;
    tick;
    b16.parallel_in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_elem", 32'(b16.serial_out_data), 32'(4 - i));
      check("t4_last", 32'(b16.serial_out_last), 32'(i == 3));
      tick;
    end
    @(negedge clk);
    check("t4_valid_after", 32'(b16.serial_out_valid), 32'd0);
    // reset mid-word discards the remainder
    b8.parallel_in_valid = 1;
    b8.parallel_in_data = 8'hA5;
    tick;
    b8.parallel_in_valid = 0;
    repeat (3) tick;
    rst = 1;
    @(negedge clk);
    check("t5_valid_in_reset", 32'(b8.serial_out_valid), 32'd0);
    tick;
    rst = 0;
    b8.parallel_in_valid = 1;
    b8.parallel_in_data = 8'hFF;
    @(negedge clk);
    check("t5_ready_after", 32'(b8.parallel_in_ready), 32'd1);
    tick;
    b8.parallel_in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_one", 32'(b8.serial_out_data), 32'd1);
      check("t5_valid", 32'(b8.serial_out_valid), 32'd1);
      tick;
    end
    @(negedge clk);
    check("t5_valid_after", 32'(b8.serial_out_valid), 32'd0);
    // random throttling on both sides of both instances
    fork
      begin
        sent8 = 0;
        cyc8 = 0;
        while (sent8 < 1000 && cyc8 < 40000) begin
          @(negedge clk);
          acc8 = b8.parallel_in_valid && b8.parallel_in_ready;
          if (acc8) sent8++;
          @(posedge clk);
          #1;
          cyc8++;
          if (acc8 || !b8.parallel_in_valid) begin
            b8.parallel_in_valid = (sent8 < 1000) && ($urandom_range(0, 3) != 0);
            b8.parallel_in_data = 8'($urandom);
          end
          b8.serial_out_ready = $urandom_range(0, 3) != 0;
        end
        b8.parallel_in_valid = 0;
        b8.serial_out_ready = 1;
        check("t6_words8", 32'(sent8), 32'd1000);
      end
      begin
        sent16 = 0;
        cyc16 = 0;
        while (sent16 < 1000 && cyc16 < 40000) begin
          @(negedge clk);
          acc16 = b16.parallel_in_valid && b16.parallel_in_ready;
          if (acc16) sent16++;
          @(posedge clk);
          #1;
          cyc16++;
          if (acc16 || !b16.parallel_in_valid) begin
            b16.parallel_in_valid = (sent16 < 1000) && ($urandom_range(0, 3) != 0);
            b16.parallel_in_data = 16'($urandom);
          end
          b16.serial_out_ready = $urandom_range(0, 3) != 0;
        end
        b16.parallel_in_valid = 0;
        b16.serial_out_ready = 1;
        check("t6_words16", 32'(sent16), 32'd1000);
      end
    join
    repeat (40) tick;
    @(negedge clk);
    #1;
    check("t6_drained8", 32'(sb[0].size()), 32'd0);
    check("t6_drained16", 32'(sb[1].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
